fetch_unit: RTL and testbench

Instruction fetch front end for the RV32I core. It owns the fetch PC and issues reads to a synchronous instruction memory. Returned words are buffered with their PCs in a small prefetch FIFO. The FIFO head is presented to decode/control and to the register/ALU/memory datapath as `Instr`, `PC` and `PCPlus4`. The datapath's `PCtargetOut` and the control unit's `PCSrc` feed back here to redirect fetch on taken branches and jumps.

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues reads to a synchronous
// instruction memory and buffers returned words with their PCs in a small
// prefetch FIFO whose head is presented to decode.
module fetch_unit #(
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]    RESET_VECTOR = '0,
  parameter int unsigned              FIFO_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  PCSrc,
  input  logic [DATA_WIDTH-1:0] PCtargetIn,
  output logic                  imem_en,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] PCPlus4,
  output logic                  valid
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;
  localparam logic [OccW-1:0]       DepthOcc = OccW'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] Four     = DATA_WIDTH'(4);

  // Fetch PC and in-flight tracking
  logic [DATA_WIDTH-1:0] r_fpc;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_tag;

  // Prefetch FIFO
  logic [DATA_WIDTH-1:0] r_mem_instr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_pc    [FIFO_DEPTH];
  logic [PtrW-1:0]       r_rptr;
  logic [PtrW-1:0]       r_wptr;
  logic [CntW-1:0]       r_count;

  // Last presented head, shown while the FIFO is empty
  logic [DATA_WIDTH-1:0] r_hold_instr;
  logic [DATA_WIDTH-1:0] r_hold_pc;
  logic [DATA_WIDTH-1:0] r_hold_pcp4;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [OccW-1:0]       w_occ;
  logic [DATA_WIDTH-1:0] w_head_instr;
  logic [DATA_WIDTH-1:0] w_head_pc;
  logic [DATA_WIDTH-1:0] w_head_pcp4;

  assign valid        = (r_count != '0);
  assign w_pop        = valid & ~stall & ~PCSrc;
  // A return arriving during a redirect belongs to the abandoned path.
  assign w_push       = r_inflight & ~PCSrc;
  // Occupancy seen by the issue rule; pop only happens with count >= 1.
  assign w_occ        = OccW'(r_count) + OccW'(r_inflight) - OccW'(w_pop);
  // rst_n gates the strobe so no read is requested while reset is held.
  assign w_issue      = rst_n & ~PCSrc & (w_occ < DepthOcc);
  assign imem_en      = w_issue;
  assign imem_addr    = r_fpc;
  assign w_head_instr = r_mem_instr[r_rptr];
  assign w_head_pc    = r_mem_pc[r_rptr];
  assign w_head_pcp4  = w_head_pc + Four;

  // Head outputs: live FIFO head when valid, otherwise the last shown values
  always_comb begin
    Instr   = r_hold_instr;
    PC      = r_hold_pc;
    PCPlus4 = r_hold_pcp4;
    if (valid) begin
      Instr   = w_head_instr;
      PC      = w_head_pc;
      PCPlus4 = w_head_pcp4;
    end
  end

  // Fetch PC advance/redirect and in-flight tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc      <= RESET_VECTOR;
      r_inflight <= 1'b0;
      r_tag      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (PCSrc) begin
        r_fpc <= {PCtargetIn[DATA_WIDTH-1:2], 2'b00};
      end else if (w_issue) begin
        r_fpc <= r_fpc + Four;
        r_tag <= r_fpc;
      end
    end
  end

  // FIFO storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wptr] <= imem_rdata;
      r_mem_pc[r_wptr]    <= r_tag;
    end
  end

  // FIFO pointers and count, flushed on redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (PCSrc) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PtrW'(w_push);
      r_rptr  <= r_rptr + PtrW'(w_pop);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  // Capture the current head so outputs hold once the FIFO drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_hold_pcp4  <= '0;
    end else if (valid) begin
      r_hold_instr <= w_head_instr;
      r_hold_pc    <= w_head_pc;
      r_hold_pcp4  <= w_head_pcp4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a synchronous imem model
// returning addr ^ 32'hA5A5_0000.
module tb_fetch_unit;

  localparam logic [31:0] Key = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        PCSrc;
  logic [31:0] PCtargetIn;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        valid;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(
    .DATA_WIDTH  (32),
    .RESET_VECTOR(32'h0),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .PCSrc     (PCSrc),
    .PCtargetIn(PCtargetIn),
    .imem_en   (imem_en),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .Instr     (Instr),
    .PC        (PC),
    .PCPlus4   (PCPlus4),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data one cycle after the strobe
  always_ff @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr ^ Key;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; PCSrc = 1'b0; PCtargetIn = '0;
    tick(); tick();
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid got=%h want=0", valid); end
    n_checks++; if (imem_en !== 1'b0) begin n_errors++; $display("FAIL rst_imem_en got=%h want=0", imem_en); end
    n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL rst_addr got=%h want=0", imem_addr); end
    n_checks++; if (PC !== 32'h0) begin n_errors++; $display("FAIL rst_pc got=%h want=0", PC); end
    n_checks++; if (Instr !== 32'h0) begin n_errors++; $display("FAIL rst_instr got=%h want=0", Instr); end
    n_checks++; if (PCPlus4 !== 32'h0) begin n_errors++; $display("FAIL rst_pcp4 got=%h want=0", PCPlus4); end
    rst_n = 1'b1;
    #1;
    // cycle 0
    n_checks++; if (imem_en !== 1'b1) begin n_errors++; $display("FAIL c0_imem_en got=%h want=1", imem_en); end
    n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL c0_addr got=%h want=0", imem_addr); end
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL c0_valid got=%h want=0", valid); end
  endtask

  task automatic test_stream();
    tick(); // cycle 1
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL c1_valid got=%h want=0", valid); end
    n_checks++; if (imem_addr !== 32'h4 || imem_en !== 1'b1) begin
      n_errors++; $display("FAIL c1_issue got=%h/%h want=1/4", imem_en, imem_addr); end
    // cycles 2 and 3: PCs 0 and 4
    for (int k = 0; k < 2; k++) begin
      logic [31:0] epc;
      tick();
      epc = 32'(k * 4);
      n_checks++; if (valid !== 1'b1 || PC !== epc) begin
        n_errors++; $display("FAIL stream_pc got=%h/%h want=1/%h", valid, PC, epc); end
      n_checks++; if (Instr !== (epc ^ Key)) begin
        n_errors++; $display("FAIL stream_instr got=%h want=%h", Instr, epc ^ Key); end
      n_checks++; if (PCPlus4 !== epc + 32'h4) begin
        n_errors++; $display("FAIL stream_pcp4 got=%h want=%h", PCPlus4, epc + 32'h4); end
    end
  endtask

  task automatic test_stall();
    // cycles 4..8 stalled with PC=8 at head
    for (int k = 0; k < 5; k++) begin
      tick();
      stall = 1'b1;
      #1;
      n_checks++; if (valid !== 1'b1 || PC !== 32'h8 || Instr !== (32'h8 ^ Key)) begin
        n_errors++; $display("FAIL stall_hold got=%h/%h/%h want=1/8/%h", valid, PC, Instr, 32'h8 ^ Key); end
      n_checks++; if (imem_en !== 1'b0) begin
        n_errors++; $display("FAIL stall_imem_en got=%h want=0", imem_en); end
    end
    tick();
    stall = 1'b0;
    #1;
    // release: pop 8 and issue 16 in the same cycle
    n_checks++; if (PC !== 32'h8 || imem_en !== 1'b1 || imem_addr !== 32'h10) begin
      n_errors++; $display("FAIL stall_release got=%h/%h/%h want=8/1/10", PC, imem_en, imem_addr); end
  endtask

  task automatic test_redirect();
    tick();
    PCSrc = 1'b1; PCtargetIn = 32'h0000_0102;
    #1;
    n_checks++; if (valid !== 1'b1 || PC !== 32'hC) begin
      n_errors++; $display("FAIL redir_head got=%h/%h want=1/c", valid, PC); end
    n_checks++; if (imem_en !== 1'b0) begin n_errors++; $display("FAIL redir_no_issue got=%h want=0", imem_en); end
    tick();
    PCSrc = 1'b0;
    #1;
    n_checks++; if (valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 32'h100) begin
      n_errors++; $display("FAIL redir_t1 got=%h/%h/%h want=0/1/100", valid, imem_en, imem_addr); end
    n_checks++; if (PC !== 32'hC) begin n_errors++; $display("FAIL redir_hold_pc got=%h want=c", PC); end
    tick();
    n_checks++; if (valid !== 1'b0 || imem_addr !== 32'h104) begin
      n_errors++; $display("FAIL redir_t2 got=%h/%h want=0/104", valid, imem_addr); end
    tick();
    n_checks++; if (valid !== 1'b1 || PC !== 32'h100 || Instr !== 32'hA5A5_0100 || PCPlus4 !== 32'h104) begin
      n_errors++; $display("FAIL redir_t3 got=%h/%h/%h/%h want=1/100/a5a50100/104", valid, PC, Instr, PCPlus4); end
    tick();
    n_checks++; if (valid !== 1'b1 || PC !== 32'h104) begin
      n_errors++; $display("FAIL redir_t4 got=%h/%h want=1/104", valid, PC); end
  endtask

  task automatic test_redirect_stall();
    tick();
    stall = 1'b1; PCSrc = 1'b1; PCtargetIn = 32'h0000_0200;
    #1;
    n_checks++; if (PC !== 32'h108 || imem_en !== 1'b0) begin
      n_errors++; $display("FAIL rs_t0 got=%h/%h want=108/0", PC, imem_en); end
    tick();
    stall = 1'b0; PCSrc = 1'b0;
    #1;
    n_checks++; if (valid !== 1'b0 || imem_addr !== 32'h200 || imem_en !== 1'b1) begin
      n_errors++; $display("FAIL rs_t1 got=%h/%h/%h want=0/200/1", valid, imem_addr, imem_en); end
    tick();
    tick();
    n_checks++; if (valid !== 1'b1 || PC !== 32'h200) begin
      n_errors++; $display("FAIL rs_t3 got=%h/%h want=1/200", valid, PC); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0; exp_pc[3] = 32'h4;
    tick();
    PCSrc = 1'b1; PCtargetIn = 32'hFFFF_FFF8;
    tick();
    PCSrc = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'hFFFF_FFF8) begin
      n_errors++; $display("FAIL wrap_addr got=%h want=fffffff8", imem_addr); end
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (valid !== 1'b1 || PC !== exp_pc[k] || Instr !== (exp_pc[k] ^ Key)) begin
        n_errors++; $display("FAIL wrap_pc got=%h/%h/%h want=1/%h/%h", valid, PC, Instr, exp_pc[k], exp_pc[k] ^ Key); end
      n_checks++; if (PCPlus4 !== exp_pc[k] + 32'h4) begin
        n_errors++; $display("FAIL wrap_pcp4 got=%h want=%h", PCPlus4, exp_pc[k] + 32'h4); end
    end
  endtask

  task automatic test_reset_midstream();
    tick();
    stall = 1'b1;
    tick();
    tick();
    n_checks++; if (valid !== 1'b1 || imem_en !== 1'b0) begin
      n_errors++; $display("FAIL full_state got=%h/%h want=1/0", valid, imem_en); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (valid !== 1'b0 || imem_en !== 1'b0) begin
      n_errors++; $display("FAIL async_rst got=%h/%h want=0/0", valid, imem_en); end
    n_checks++; if (PC !== 32'h0 || Instr !== 32'h0 || PCPlus4 !== 32'h0 || imem_addr !== 32'h0) begin
      n_errors++; $display("FAIL async_rst_out got=%h/%h/%h/%h want=0/0/0/0", PC, Instr, PCPlus4, imem_addr); end
    tick();
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0) begin
      n_errors++; $display("FAIL restart_c0 got=%h/%h/%h want=1/0/0", imem_en, imem_addr, valid); end
    tick();
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL restart_c1 got=%h want=0", valid); end
    tick();
    n_checks++; if (valid !== 1'b1 || PC !== 32'h0 || Instr !== Key) begin
      n_errors++; $display("FAIL restart_c2 got=%h/%h/%h want=1/0/%h", valid, PC, Instr, Key); end
    tick();
    n_checks++; if (valid !== 1'b1 || PC !== 32'h4) begin
      n_errors++; $display("FAIL restart_c3 got=%h/%h want=1/4", valid, PC); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
